// File: rtl/overlay_frame_sched_if.sv
// Bus bundle for overlay_frame_sched: center input, SRAM read port and
// output pixel stream. master = scheduler side, slave = environment side.
interface overlay_frame_sched_if #(
  parameter int unsigned AW = 20
);
  // coordinate source
  logic          i_ctr_valid;
  logic          o_ctr_ready;
  logic [9:0]    i_ctr_row;
  logic [9:0]    i_ctr_col;
  // frame memory read port
  logic          o_rd_req;
  logic          i_rd_ack;
  logic [AW-1:0] o_rd_addr;
  logic          i_rd_valid;
  logic [31:0]   i_rd_data;
  // output pixel stream
  logic          o_valid;
  logic          i_ready;
  logic [31:0]   o_data;
  logic          o_sof;
  logic          o_eol;

  modport master (
    input  i_ctr_valid, i_ctr_row, i_ctr_col,
    input  i_rd_ack, i_rd_valid, i_rd_data, i_ready,
    output o_ctr_ready, o_rd_req, o_rd_addr, o_valid, o_data, o_sof, o_eol
  );

  modport slave (
    output i_ctr_valid, i_ctr_row, i_ctr_col,
    output i_rd_ack, i_rd_valid, i_rd_data, i_ready,
    input  o_ctr_ready, o_rd_req, o_rd_addr, o_valid, o_data, o_sof, o_eol
  );
endinterface

// File: rtl/overlay_frame_sched.sv
// overlay_frame_sched: sequences one overlay pass over a W x H frame.
// Issues linear reads under credit flow control, tags each request with an
// inside-box flag, replaces boxed pixels with BOX_COLOR and streams results.
// Optional macro CENTER_CLAMP_EN: clamp the active center at LOAD so the box
// always lies fully on-frame.
module overlay_frame_sched #(
  parameter int unsigned W         = 800,
  parameter int unsigned H         = 600,
  parameter int unsigned HALF      = 64,
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] BOX_COLOR = 32'h0000_03FF,
  parameter int unsigned AW        = 20
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_continuous,
  input  logic                  i_abort,
  overlay_frame_sched_if.master bus,
  output logic                  o_busy,
  output logic                  o_frame_done
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0]        DEPTH_C  = (CW+1)'(DEPTH);
  localparam logic [9:0]         COL_LAST = 10'(W - 1);
  localparam logic [9:0]         ROW_LAST = 10'(H - 1);
  localparam logic signed [11:0] HALF_S   = 12'(HALF);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_DONE, S_FLUSH} state_t;
  state_t state, state_nx;

  logic [9:0]    shadow_row, shadow_col, act_row, act_col, ld_row, ld_col;
  logic [9:0]    row, col, out_row, out_col;
  logic [AW-1:0] addr;
  logic [CW-1:0] inflight, fifo_cnt;
  logic [CW:0]   credits;
  logic [PW-1:0] tag_wp, tag_rp, pix_wp, pix_rp;
  logic [DEPTH-1:0] tag_mem;
  logic [31:0]   pix_mem [DEPTH];
  logic [31:0]   push_data;
  logic          ack, rd_in, push, pop, last_req, abort_go, inbox;
  logic signed [11:0] r_s, c_s, rlo, rhi, clo, chi;

  assign credits  = {1'b0, inflight} + {1'b0, fifo_cnt};
  assign abort_go = i_abort && (state != S_IDLE);
  assign ack      = bus.o_rd_req && bus.i_rd_ack;
  assign rd_in    = bus.i_rd_valid && (inflight != '0);
  assign push     = rd_in && (state != S_FLUSH) && !abort_go;
  assign pop      = bus.o_valid && bus.i_ready;
  assign last_req = ack && (row == ROW_LAST) && (col == COL_LAST);
  assign push_data = tag_mem[tag_rp] ? BOX_COLOR : bus.i_rd_data;

  // box membership of the request being issued (signed, so off-frame edges clip)
  assign r_s   = $signed({2'b00, row});
  assign c_s   = $signed({2'b00, col});
  assign rlo   = $signed({2'b00, act_row}) - HALF_S;
  assign rhi   = $signed({2'b00, act_row}) + HALF_S;
  assign clo   = $signed({2'b00, act_col}) - HALF_S;
  assign chi   = $signed({2'b00, act_col}) + HALF_S;
  assign inbox = (rlo <= r_s) && (r_s < rhi) && (clo <= c_s) && (c_s < chi);

  // center value captured into the active register at LOAD
  always_comb begin
    ld_row = shadow_row;
    ld_col = shadow_col;
`ifdef CENTER_CLAMP_EN
    if (shadow_row < 10'(HALF))          ld_row = 10'(HALF);
    else if (shadow_row > 10'(H - HALF)) ld_row = 10'(H - HALF);
    if (shadow_col < 10'(HALF))          ld_col = 10'(HALF);
    else if (shadow_col > 10'(W - HALF)) ld_col = 10'(W - HALF);
`endif
  end

  // next-state and control outputs
  always_comb begin
    state_nx     = state;
    bus.o_rd_req = 1'b0;
    o_busy       = (state != S_IDLE);
    o_frame_done = (state == S_DONE);
    case (state)
      S_IDLE:  if (i_start) state_nx = S_LOAD;
      S_LOAD:  state_nx = S_RUN;
      S_RUN: begin
        bus.o_rd_req = !i_abort && (credits < DEPTH_C);
        if (last_req) state_nx = S_DRAIN;
      end
      S_DRAIN: if (inflight == '0 && fifo_cnt == '0) state_nx = S_DONE;
      S_DONE:  state_nx = i_continuous ? S_LOAD : S_IDLE;
      S_FLUSH: if (inflight == '0) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (abort_go) state_nx = S_FLUSH;
  end

  // stream outputs; data is gated so an empty FIFO presents zeros
  always_comb begin
    bus.o_ctr_ready = 1'b1;
    bus.o_valid     = (fifo_cnt != '0) && (state != S_FLUSH);
    bus.o_data      = bus.o_valid ? pix_mem[pix_rp] : '0;
    bus.o_sof       = bus.o_valid && (out_row == '0) && (out_col == '0);
    bus.o_eol       = bus.o_valid && (out_col == COL_LAST);
    bus.o_rd_addr   = addr;
  end

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  // shadow center takes every offer; active center only updates at LOAD
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shadow_row <= '0; shadow_col <= '0; act_row <= '0; act_col <= '0;
    end else begin
      if (bus.i_ctr_valid) begin
        shadow_row <= bus.i_ctr_row;
        shadow_col <= bus.i_ctr_col;
      end
      if (state == S_LOAD) begin
        act_row <= ld_row;
        act_col <= ld_col;
      end
    end
  end

  // request-side raster position and linear address incrementer
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      row <= '0; col <= '0; addr <= '0;
    end else if (state == S_LOAD) begin
      row <= '0; col <= '0; addr <= '0;
    end else if (ack) begin
      addr <= addr + AW'(1);
      if (col == COL_LAST) begin
        col <= '0;
        row <= row + 10'd1;
      end else begin
        col <= col + 10'd1;
      end
    end
  end

  // in-flight count and tag FIFO pointers (tags retire with returning data)
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      inflight <= '0; tag_wp <= '0; tag_rp <= '0;
    end else begin
      if (ack)   tag_wp <= tag_wp + PW'(1);
      if (rd_in) tag_rp <= tag_rp + PW'(1);
      if (ack && !rd_in)      inflight <= inflight + CW'(1);
      else if (!ack && rd_in) inflight <= inflight - CW'(1);
    end
  end

  // tag storage
  always_ff @(posedge i_clk) begin
    if (ack) tag_mem[tag_wp] <= inbox;
  end

  // pixel FIFO control; abort empties it at once
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fifo_cnt <= '0; pix_wp <= '0; pix_rp <= '0;
    end else if (abort_go) begin
      fifo_cnt <= '0; pix_wp <= '0; pix_rp <= '0;
    end else begin
      if (push) pix_wp <= pix_wp + PW'(1);
      if (pop)  pix_rp <= pix_rp + PW'(1);
      if (push && !pop)      fifo_cnt <= fifo_cnt + CW'(1);
      else if (!push && pop) fifo_cnt <= fifo_cnt - CW'(1);
    end
  end

  // pixel storage
  always_ff @(posedge i_clk) begin
    if (push) pix_mem[pix_wp] <= push_data;
  end

  // output-side raster position for sof/eol
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_row <= '0; out_col <= '0;
    end else if (state == S_LOAD) begin
      out_row <= '0; out_col <= '0;
    end else if (pop) begin
      if (out_col == COL_LAST) begin
        out_col <= '0;
        out_row <= out_row + 10'd1;
      end else begin
        out_col <= out_col + 10'd1;
      end
    end
  end
endmodule

// File: tb/tb_overlay_frame_sched.sv
// Scoreboard bench for overlay_frame_sched on a reduced 16x12 frame.
// Memory model acks requests and returns data after a programmable latency;
// expected pixels are queued at ack time and checked by the output monitor.
module tb_overlay_frame_sched;
  localparam int W = 16, H = 12, HALF = 4, DEPTH = 4, NPIX = W * H;
  localparam logic [31:0] BOX = 32'h0000_03FF;

  typedef struct { logic [31:0] data; logic sof; logic eol; int addr; } exp_t;
  typedef struct { int addr; int due; } pend_t;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, cont = 1'b0, abort = 1'b0;
  logic busy, done;

  exp_t  sb[$];
  pend_t pend[$];
  int compared = 0, mismatched = 0;
  int pop_cnt = 0, done_cnt = 0, ack_cnt = 0, occ_base = 0, max_occ = 0;
  int lat = 1, ready_mode = 0, ack_mode = 0;
  int sh_row = 0, sh_col = 0, act_row = 0, act_col = 0;

  overlay_frame_sched_if #(.AW(20)) bus ();

  overlay_frame_sched #(
    .W(16), .H(12), .HALF(4), .DEPTH(4), .BOX_COLOR(32'h0000_03FF), .AW(20)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_continuous(cont),
    .i_abort(abort), .bus(bus.master), .o_busy(busy), .o_frame_done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pix(int a);
    return 32'hA500_0000 | 32'(a);
  endfunction

  function automatic bit in_box(int r, int c, int cr, int cc);
    int er = cr, ec = cc;
`ifdef CENTER_CLAMP_EN
    if (er < HALF) er = HALF; else if (er > H - HALF) er = H - HALF;
    if (ec < HALF) ec = HALF; else if (ec > W - HALF) ec = W - HALF;
`endif
    return (r >= er - HALF) && (r < er + HALF) && (c >= ec - HALF) && (c < ec + HALF);
  endfunction

  task automatic chk(string name, longint act, longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // memory model: returns, ready/ack policy, request capture
  initial begin
    int cyc = 0, exp_addr = 0, occ, r, c;
    pend_t p;
    exp_t  e;
    bus.i_rd_ack = 1'b0; bus.i_rd_valid = 1'b0; bus.i_rd_data = '0; bus.i_ready = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        pend.delete();
        bus.i_rd_valid = 1'b0; bus.i_rd_ack = 1'b0; bus.i_ready = 1'b0;
        exp_addr = 0; occ_base = ack_cnt - pop_cnt;
        continue;
      end
      bus.i_ready = (ready_mode == 0) ? 1'b1 : (cyc % 3 == 0);
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        p = pend.pop_front();
        bus.i_rd_valid = 1'b1; bus.i_rd_data = pix(p.addr);
      end else begin
        bus.i_rd_valid = 1'b0; bus.i_rd_data = 32'hDEAD_BEEF;
      end
      bus.i_rd_ack = (ack_mode == 0) ? 1'b1 : (cyc % 2 == 0);
      if (!busy) begin
        exp_addr = 0; occ_base = ack_cnt - pop_cnt;
      end
      if (bus.o_rd_req && bus.i_rd_ack) begin
        occ = ack_cnt - pop_cnt - occ_base;
        if (occ + 1 > max_occ) max_occ = occ + 1;
        compared++;
        if (bus.o_rd_addr !== 20'(exp_addr)) begin
          mismatched++;
          $display("FAIL rd_addr: got %0d expected %0d", bus.o_rd_addr, exp_addr);
        end
        if (exp_addr == 0) begin act_row = sh_row; act_col = sh_col; end
        r = exp_addr / W; c = exp_addr % W;
        e.data = in_box(r, c, act_row, act_col) ? BOX : pix(exp_addr);
        e.sof = (exp_addr == 0); e.eol = (c == W - 1); e.addr = exp_addr;
        sb.push_back(e);
        pend.push_back('{exp_addr, cyc + lat});
        ack_cnt++;
        exp_addr = (exp_addr == NPIX - 1) ? 0 : exp_addr + 1;
      end
    end
  end

  // output monitor: pops the scoreboard on every accepted pixel
  initial begin
    exp_t e;
    logic [31:0] held = '0;
    bit hold = 1'b0;
    forever begin
      @(negedge clk); #1;
      if (done) done_cnt++;
      if (hold && bus.o_valid) begin
        compared++;
        if (bus.o_data !== held) begin
          mismatched++;
          $display("FAIL hold_data: got %h expected %h", bus.o_data, held);
        end
      end
      hold = bus.o_valid && !bus.i_ready;
      held = bus.o_data;
      if (!busy) sb.delete();
      else if (bus.o_valid && bus.i_ready) begin
        pop_cnt++;
        compared++;
        if (sb.size() == 0) begin
          mismatched++;
          $display("FAIL pixel: got unexpected data=%h expected no output", bus.o_data);
        end else begin
          e = sb.pop_front();
          if ({bus.o_data, bus.o_sof, bus.o_eol} !== {e.data, e.sof, e.eol}) begin
            mismatched++;
            $display("FAIL pixel addr %0d: got data=%h sof=%b eol=%b expected data=%h sof=%b eol=%b",
                     e.addr, bus.o_data, bus.o_sof, bus.o_eol, e.data, e.sof, e.eol);
          end
        end
      end
    end
  end

  task automatic set_center(int r, int c);
    @(posedge clk); #1;
    bus.i_ctr_valid = 1'b1; bus.i_ctr_row = 10'(r); bus.i_ctr_col = 10'(c);
    sh_row = r; sh_col = c;
    @(posedge clk); #1;
    bus.i_ctr_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(int target, string name);
    for (int k = 0; k < 4000 && done_cnt < target; k++) begin @(negedge clk); #2; end
    chk({name, "_done_seen"}, done_cnt >= target, 1);
  endtask

  task automatic wait_idle(string name);
    for (int k = 0; k < 200 && busy; k++) begin @(negedge clk); #2; end
    chk({name, "_idle"}, busy, 0);
  endtask

  task automatic wait_pops(int target, string name);
    for (int k = 0; k < 2000 && pop_cnt < target; k++) begin @(negedge clk); #2; end
    chk({name, "_progress"}, pop_cnt >= target, 1);
  endtask

  task automatic run_frame(string name);
    int p0 = pop_cnt, d0 = done_cnt;
    pulse_start();
    wait_done(d0 + 1, name);
    wait_idle(name);
    chk({name, "_pixels"}, pop_cnt - p0, NPIX);
    chk({name, "_done_count"}, done_cnt - d0, 1);
  endtask

  initial begin
    int p0, d0, vseen;
    bus.i_ctr_valid = 1'b0; bus.i_ctr_row = '0; bus.i_ctr_col = '0;
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_valid", bus.o_valid, 0);
    chk("reset_rd_req", bus.o_rd_req, 0);
    chk("reset_ctr_ready", bus.o_ctr_ready, 1);
    chk("reset_frame_done", done, 0);
    chk("reset_rd_addr", bus.o_rd_addr, 0);
    #20;
    @(posedge clk); #1 rst_n = 1'b1;

    // basic frame: box rows 2..9, cols 4..11
    set_center(6, 8);
    run_frame("basic");

    // box clipped at top-left corner
    set_center(1, 2);
    run_frame("clip");

    // slow sink, long latency, sparse acks: credits must cap at DEPTH
    lat = 5; ready_mode = 1; ack_mode = 1;
    run_frame("backpressure");
    chk("max_occupancy", max_occ, DEPTH);
    lat = 1; ready_mode = 0; ack_mode = 0;

    // center change mid-frame applies only to the following frame
    set_center(6, 8);
    p0 = pop_cnt; d0 = done_cnt;
    @(posedge clk); #1 cont = 1'b1;
    pulse_start();
    wait_pops(p0 + 60, "midframe");
    set_center(3, 3);
    wait_done(d0 + 1, "midframe_f1");
    @(posedge clk); #1 cont = 1'b0;
    wait_done(d0 + 2, "midframe_f2");
    wait_idle("midframe");
    chk("midframe_pixels", pop_cnt - p0, 2 * NPIX);
    chk("midframe_done_count", done_cnt - d0, 2);

    // abort with reads in flight
    lat = 3;
    p0 = pop_cnt; d0 = done_cnt;
    pulse_start();
    wait_pops(p0 + 20, "abort");
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0; start = 1'b1;
    chk("abort_valid_drop", bus.o_valid, 0);
    chk("abort_rd_req", bus.o_rd_req, 0);
    chk("abort_flush_busy", busy, 1);
    @(posedge clk); #1 start = 1'b0;
    vseen = 0;
    for (int k = 0; k < 50 && busy; k++) begin
      @(negedge clk); #2;
      if (bus.o_valid) vseen++;
    end
    chk("abort_no_valid", vseen, 0);
    wait_idle("abort");
    repeat (5) @(negedge clk);
    chk("abort_start_ignored", busy, 0);
    chk("abort_no_done", done_cnt - d0, 0);
    run_frame("after_abort");
    lat = 1;

    // asynchronous reset mid-frame clears outputs and the shadow center
    set_center(5, 5);
    p0 = pop_cnt;
    pulse_start();
    wait_pops(p0 + 30, "reset_mid");
    @(posedge clk); #1 rst_n = 1'b0;
    sh_row = 0; sh_col = 0;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_valid", bus.o_valid, 0);
    chk("rst_mid_rd_req", bus.o_rd_req, 0);
    #20;
    @(posedge clk); #1 rst_n = 1'b1;
    run_frame("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got no completion expected finish before 800000ns");
    $fatal(1, "watchdog expired");
  end
endmodule
